// File: rtl/slave_mem_burst_if.sv
// Serial bus between the arbiter-side master and the burst memory slave.
interface slave_mem_burst_if #(
   parameter int DATA_W = 8
);
   logic              AD_SEL;
   logic              B_RW;
   logic              B_BUS_OUT;
   logic              B_BUS_IN;
   logic              B_ACK;
   logic              B_SBSY;
   logic              B_READY;
   logic              S_DVALID;
   logic [DATA_W-1:0] S_DOUT;

   modport master (
      output AD_SEL, B_RW, B_BUS_OUT,
      input  B_BUS_IN, B_ACK, B_SBSY, B_READY, S_DVALID, S_DOUT
   );

   modport slave (
      input  AD_SEL, B_RW, B_BUS_OUT,
      output B_BUS_IN, B_ACK, B_SBSY, B_READY, S_DVALID, S_DOUT
   );
endinterface

// File: rtl/slave_mem_burst.sv
// Serial-bus memory slave: LSB-first header (address + burst length), then
// bit-serial write or read bursts with wrapping auto-increment address.
module slave_mem_burst #(
   parameter int                MEM_AW   = 12,
   parameter int                DATA_W   = 8,
   parameter int                BLEN_W   = 2,
   parameter logic [DATA_W-1:0] INIT_VAL = 8'hAD
) (
   input logic              CLK,
   input logic              RSTN,
   slave_mem_burst_if.slave bus
);
   localparam int FRAME_W = MEM_AW + BLEN_W;
   localparam int DEPTH   = 2 ** MEM_AW;
   localparam int CNT_MAX = (FRAME_W > DATA_W) ? FRAME_W : DATA_W;
   localparam int CNT_W   = $clog2(CNT_MAX);

   typedef enum logic [2:0] {IDLE, ADDR, ACK_A, WRITE, ACK_W, READ} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [FRAME_W-1:0] header;
   logic [MEM_AW-1:0]  addr;
   logic [BLEN_W-1:0]  beats_left;
   logic [DATA_W-1:0]  wr_shift;
   logic [DATA_W-1:0]  rd_shift;
   logic [DATA_W-1:0]  mem [DEPTH];

   logic [MEM_AW-1:0]  hdr_addr;
   logic [BLEN_W-1:0]  hdr_blen;
   logic [MEM_AW-1:0]  next_addr;
   logic [DATA_W-1:0]  wr_word;
   logic               last_bit;
   logic               wr_en;

   assign hdr_addr  = header[MEM_AW-1:0];
   assign hdr_blen  = header[FRAME_W-1:MEM_AW];
   assign next_addr = addr + MEM_AW'(1);
   assign last_bit  = (cnt == CNT_W'(DATA_W - 1));
   assign wr_word   = {bus.B_BUS_OUT, wr_shift[DATA_W-1:1]};
   // Dropping AD_SEL on the completing edge suppresses the write.
   assign wr_en     = (state == WRITE) && bus.AD_SEL && last_bit;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
      end else if (wr_en) begin
         mem[addr] <= wr_word;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state        <= IDLE;
         cnt          <= '0;
         addr         <= '0;
         beats_left   <= '0;
         bus.B_BUS_IN <= 1'b0;
         bus.B_ACK    <= 1'b0;
         bus.B_SBSY   <= 1'b0;
         bus.B_READY  <= 1'b0;
         bus.S_DVALID <= 1'b0;
         bus.S_DOUT   <= '0;
      end else begin
         bus.B_READY  <= bus.AD_SEL;
         bus.B_ACK    <= 1'b0;
         bus.S_DVALID <= 1'b0;
         if (state != IDLE && !bus.AD_SEL) begin
            state        <= IDLE;
            bus.B_SBSY   <= 1'b0;
            bus.B_BUS_IN <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.AD_SEL) begin
                     state      <= ADDR;
                     cnt        <= '0;
                     bus.B_SBSY <= 1'b1;
                  end
               end
               ADDR: begin
                  header <= {bus.B_BUS_OUT, header[FRAME_W-1:1]};
                  cnt    <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(FRAME_W - 1)) begin
                     state     <= ACK_A;
                     bus.B_ACK <= 1'b1;
                  end
               end
               ACK_A: begin
                  addr       <= hdr_addr;
                  beats_left <= hdr_blen;
                  cnt        <= '0;
                  if (bus.B_RW) begin
                     state <= WRITE;
                  end else begin
                     state        <= READ;
                     bus.B_BUS_IN <= mem[hdr_addr][0];
                     rd_shift     <= mem[hdr_addr] >> 1;
                  end
               end
               WRITE: begin
                  wr_shift <= wr_word;
                  cnt      <= cnt + CNT_W'(1);
                  if (last_bit) begin
                     state        <= ACK_W;
                     bus.B_ACK    <= 1'b1;
                     bus.S_DVALID <= 1'b1;
                     bus.S_DOUT   <= wr_word;
                  end
               end
               ACK_W: begin
                  cnt <= '0;
                  if (beats_left != '0) begin
                     beats_left <= beats_left - BLEN_W'(1);
                     addr       <= next_addr;
                     state      <= WRITE;
                  end else begin
                     state      <= IDLE;
                     bus.B_SBSY <= 1'b0;
                  end
               end
               READ: begin
                  if (last_bit) begin
                     cnt <= '0;
                     // Next word's bit 0 follows immediately, no gap cycle.
                     if (beats_left != '0) begin
                        beats_left   <= beats_left - BLEN_W'(1);
                        addr         <= next_addr;
                        bus.B_BUS_IN <= mem[next_addr][0];
                        rd_shift     <= mem[next_addr] >> 1;
                     end else begin
                        state        <= IDLE;
                        bus.B_SBSY   <= 1'b0;
                        bus.B_BUS_IN <= 1'b0;
                     end
                  end else begin
                     cnt          <= cnt + CNT_W'(1);
                     bus.B_BUS_IN <= rd_shift[0];
                     rd_shift     <= rd_shift >> 1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
